// File: rtl/output_ram.sv
// output_ram: per-iteration result store for the CA1 datapath.
// Tracks filled entries, fill count and out-of-range index hits.
module output_ram #(
    parameter int r  = 8,
    parameter int n  = 32,
    parameter int aw = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [aw-1:0]            i,
    input  logic [n-1:0]             pi,
    output logic [n-1:0]             rdata,
    output logic [r-1:0]             valid,
    output logic [$clog2(r+1)-1:0]   wr_count,
    output logic                     full,
    output logic                     oor
);

    localparam int cw = $clog2(r + 1);
    localparam int ia = (r > 1) ? $clog2(r) : 1;
    localparam logic [aw:0] r_ext = (aw + 1)'(r);

    logic [n-1:0]  mem [r];
    logic          in_range;
    logic [ia-1:0] idx;

    assign in_range = ({1'b0, i} < r_ext);
    assign idx      = i[ia-1:0];

    // Read-before-write port: shows the stored word, zero when out of range.
    always_comb begin
        rdata = '0;
        if (in_range) begin
            rdata = mem[idx];
        end
    end

    assign full = (wr_count == cw'(r));

    // Storage array: cleared on reset, written every in-range cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < r; k++) begin
                mem[k] <= '0;
            end
        end else if (in_range) begin
            mem[idx] <= pi;
        end
    end

    // Fill tracking: count only first writes so the count saturates at r.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            wr_count <= '0;
        end else if (in_range) begin
            valid[idx] <= 1'b1;
            if (!valid[idx]) begin
                wr_count <= wr_count + cw'(1);
            end
        end
    end

    // One-cycle flag for an out-of-range index on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            oor <= 1'b0;
        end else begin
            oor <= !in_range;
        end
    end

endmodule

// File: tb/tb_output_ram.sv
// tb_output_ram: directed checks of output_ram with hand-computed values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_output_ram;

    logic        clk;
    logic        rst;
    logic [4:0]  i;
    logic [31:0] pi;
    logic [31:0] rdata;
    logic [7:0]  valid;
    logic [3:0]  wr_count;
    logic        full;
    logic        oor;

    int total;
    int bad;

    output_ram #(.r(8), .n(32), .aw(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .i        (i),
        .pi       (pi),
        .rdata    (rdata),
        .valid    (valid),
        .wr_count (wr_count),
        .full     (full),
        .oor      (oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        i     = 5'd0;
        pi    = 32'd0;

        // 1. reset and first write
        step();
        step();
        chk("rst_rdata", rdata, 0);
        chk("rst_valid", valid, 0);
        chk("rst_cnt", wr_count, 0);
        chk("rst_full", full, 0);
        chk("rst_oor", oor, 0);
        rst = 1'b0;
        step();
        chk("first_valid", valid, 8'h01);
        chk("first_cnt", wr_count, 1);
        chk("first_rdata", rdata, 0);

        // 2. sequential writes
        i = 5'd1; pi = 32'd10; step();
        i = 5'd2; pi = 32'd2;  step();
        i = 5'd3; pi = 32'd4;  step();
        chk("seq_valid", valid, 8'h0f);
        chk("seq_cnt", wr_count, 4);
        chk("seq_full", full, 0);
        i = 5'd1; #1 chk("seq_m1", rdata, 10);
        i = 5'd2; #1 chk("seq_m2", rdata, 2);
        i = 5'd3; #1 chk("seq_m3", rdata, 4);

        // 3. fill and overwrite
        for (int k = 0; k < 8; k++) begin
            i  = 5'(k);
            pi = 32'(k * 3);
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_cnt", wr_count, 8);
        chk("fill_valid", valid, 8'hff);
        i = 5'd5; pi = 32'hdeadbeef;
        step();
        chk("ovw_cnt", wr_count, 8);
        chk("ovw_rdata", rdata, 32'hdeadbeef);
        chk("ovw_full", full, 1);

        // 4. out of range, then boundary index r
        i = 5'd9; pi = 32'd77;
        step();
        chk("oor_set", oor, 1);
        chk("oor_rdata", rdata, 0);
        chk("oor_cnt", wr_count, 8);
        chk("oor_valid", valid, 8'hff);
        i = 5'd5; pi = 32'hdeadbeef;
        step();
        chk("oor_clr", oor, 0);
        for (int k = 0; k < 8; k++) begin
            i = 5'(k);
            #1 chk($sformatf("oor_m%0d", k), rdata,
                   (k == 5) ? 64'hdeadbeef : 64'(k * 3));
        end
        i = 5'd8; pi = 32'd1;
        step();
        chk("oor8_set", oor, 1);
        chk("oor8_rdata", rdata, 0);
        chk("oor8_cnt", wr_count, 8);

        // 5. read-before-write
        i = 5'd2; pi = 32'd2;
        step();
        chk("oor8_clr", oor, 0);
        pi = 32'd50;
        #1 chk("rbw_before", rdata, 2);
        step();
        chk("rbw_after", rdata, 50);

        // 6. mid-run reset from full state
        chk("pre_rst_full", full, 1);
        rst = 1'b1; i = 5'd4; pi = 32'd99;
        step();
        chk("mrst_valid", valid, 0);
        chk("mrst_cnt", wr_count, 0);
        chk("mrst_full", full, 0);
        chk("mrst_oor", oor, 0);
        chk("mrst_m4", rdata, 0);
        for (int k = 0; k < 8; k++) begin
            i = 5'(k);
            #1 chk($sformatf("mrst_m%0d", k), rdata, 0);
        end
        rst = 1'b0; i = 5'd0; pi = 32'd0;
        step();
        chk("resume_cnt", wr_count, 1);
        chk("resume_valid", valid, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
